// File: rtl/peripheral_mpi_pkg.sv
// Shared types for the MPI peripheral egress path: arbiter state encoding
// and the pointer-width helper used by the VC multiplexer.
package peripheral_mpi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Channel-index width: $clog2(n), but never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peripheral_mpi_vc_mux_if.sv
// Bundle of the N ingress flit streams and the single merged egress link.
// The slave modport is the multiplexer's view, the master modport the environment's.
interface peripheral_mpi_vc_mux_if #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 2
);

    logic [N*NOC_FLIT_WIDTH-1:0] in_flit;
    logic [N-1:0]                in_last;
    logic [N-1:0]                in_valid;
    logic [N-1:0]                in_ready;
    logic [NOC_FLIT_WIDTH-1:0]   out_flit;
    logic                        out_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [N-1:0]                out_sel;

    modport master (
        output in_flit,
        output in_last,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_flit,
        input  out_last,
        input  out_valid,
        input  out_sel
    );

    modport slave (
        input  in_flit,
        input  in_last,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_flit,
        output out_last,
        output out_valid,
        output out_sel
    );

endinterface

// File: rtl/peripheral_mpi_skid.sv
// Two-entry valid/ready skid register: full throughput, one cycle latency,
// upstream ready comes straight from a flop.
module peripheral_mpi_skid #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             push;
    logic             pop;

    // Emptied entries are cleared so the outputs read zero whenever invalid.
    always_comb begin
        pop          = main_valid_q & out_ready;
        push         = in_valid & ~skid_valid_q;
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (pop) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!main_valid_q || pop) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (pop) begin
            main_d       = '0;
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_data  = main_q;
    assign out_valid = main_valid_q;

endmodule

// File: rtl/peripheral_mpi_vc_mux.sv
// Packet-atomic round-robin N-to-1 flit multiplexer for the MPI NoC egress.
// Define PERIPHERAL_MPI_VC_MUX_REG_EN to register the output through a skid stage.
module peripheral_mpi_vc_mux
    import peripheral_mpi_pkg::*;
#(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 2
) (
    input logic                    clk,
    input logic                    rst,
    peripheral_mpi_vc_mux_if.slave bus
);

    localparam int             PW       = ptr_width(N);
    localparam logic [PW-1:0]  LAST_IDX = PW'(N - 1);

    state_t                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [PW-1:0]             owner_q, owner_d;

    logic [NOC_FLIT_WIDTH-1:0] flit_arr [N];
    logic [PW-1:0]             rr_grant;
    logic                      rr_found;
    logic [PW-1:0]             grant;
    logic                      mux_valid;
    logic                      mux_last;
    logic [NOC_FLIT_WIDTH-1:0] mux_flit;
    logic [N-1:0]              mux_sel;
    logic [N-1:0]              in_ready_int;
    logic                      link_ready;
    logic                      xfer;

    // First requester at or after start, wrapping; MSB flags that one exists.
    function automatic logic [PW:0] rr_search(input logic [N-1:0] valid,
                                              input logic [PW-1:0] start);
        logic [PW:0]   result;
        logic [PW-1:0] idx;
        result = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(start) + k) % N);
            if (valid[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            flit_arr[i] = bus.in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (mux_last) begin
                        ptr_d = next_idx(grant);
                    end else begin
                        state_d = LOCKED;
                        owner_d = grant;
                    end
                end
            end
            LOCKED: begin
                if (xfer && mux_last) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While locked only the owner is looked at; everything is muted in reset.
    always_comb begin
        {rr_found, rr_grant} = rr_search(bus.in_valid, ptr_q);
        grant        = (state_q == LOCKED) ? owner_q : rr_grant;
        mux_valid    = ~rst & ((state_q == LOCKED) ? bus.in_valid[owner_q] : rr_found);
        mux_flit     = '0;
        mux_last     = 1'b0;
        mux_sel      = '0;
        in_ready_int = '0;
        if (mux_valid) begin
            mux_flit       = flit_arr[grant];
            mux_last       = bus.in_last[grant];
            mux_sel[grant] = 1'b1;
        end
        if (!rst && ((state_q == LOCKED) || rr_found)) begin
            in_ready_int[grant] = link_ready;
        end
        xfer = mux_valid & link_ready;
    end

    assign bus.in_ready = in_ready_int;

`ifdef PERIPHERAL_MPI_VC_MUX_REG_EN
    localparam int SKID_W = NOC_FLIT_WIDTH + 1 + N;

    logic [SKID_W-1:0] skid_out;
    logic              skid_in_ready;

    peripheral_mpi_skid #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({mux_sel, mux_last, mux_flit}),
        .in_valid  (mux_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign link_ready   = skid_in_ready;
    assign bus.out_flit = skid_out[NOC_FLIT_WIDTH-1:0];
    assign bus.out_last = skid_out[NOC_FLIT_WIDTH];
    assign bus.out_sel  = skid_out[SKID_W-1 -: N];
`else
    assign link_ready    = bus.out_ready;
    assign bus.out_flit  = mux_flit;
    assign bus.out_last  = mux_last;
    assign bus.out_valid = mux_valid;
    assign bus.out_sel   = mux_sel;
`endif

endmodule

// File: doc/peripheral_mpi_vc_mux.md
# peripheral_mpi_vc_mux

Packet-atomic N-to-1 multiplexer on the NoC egress side of the MPI peripheral. It takes the N per-channel flit streams produced by the MPI message buffer and merges them onto one physical NoC output link. Arbitration is round-robin at packet granularity, so a packet is never interleaved with flits of another channel. An optional output register stage decouples the link timing.

## Interface
Parameters:
- NOC_FLIT_WIDTH, 32, flit width in bits
- N, 2, number of input channels (≥1)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_flit  in  N*NOC_FLIT_WIDTH  channel i occupies bits [i*W +: W]
- in_last  in  N  last flit of packet, per channel
- in_valid  in  N  flit valid, per channel
- in_ready  out  N  flit accepted, per channel
- out_flit  out  NOC_FLIT_WIDTH  merged flit
- out_last  out  1  last flit of packet
- out_valid  out  1  merged flit valid
- out_ready  in  1  link accepts flit
- out_sel  out  N  one-hot source channel of the current out flit; 0 when out_valid=0

## Operation
- Transfer on any port happens when valid & ready in the same cycle.
- State register: IDLE or LOCKED. Owner register: log2(N) bits (min 1). Round-robin pointer ptr: log2(N) bits.
- IDLE: grant = first i with in_valid[i], searching ptr, ptr+1, … modulo N. Granted channel drives the output. in_ready[grant] = output-side ready. All other in_ready = 0.
  - Transfer with in_last=1 (single-flit packet): stay IDLE, ptr <= grant+1 mod N.
  - Transfer with in_last=0: go LOCKED, owner <= grant.
  - No transfer: stay IDLE, ptr unchanged. The grant may change next cycle; nothing has been committed yet.
- LOCKED: output driven only by channel owner. in_ready[owner] = output-side ready; all others 0. in_valid of other channels is ignored.
  - Transfer with in_last=1: go IDLE, ptr <= owner+1 mod N.
  - Owner in_valid low: out_valid low and the lock is held. No timeout.
- Flits pass through unmodified. No header inspection, no reordering within a channel.
- N=1: the arbiter degenerates to a pass-through. ptr and owner stay 0.
- Reset values: state IDLE, ptr 0, owner 0, out_valid 0, out_last 0, out_flit 0, out_sel 0, in_ready 0 during reset.
- Reset mid-packet: the lock is dropped and no flits are replayed. Recovery is the upstream's responsibility.

## Timing
- Macro absent: combinational path from in_* to out_*, zero latency, 1 flit/cycle sustained. out_ready reaches in_ready combinationally.
- In IDLE, the first flit of a packet leaves in the same cycle it is granted. There is no arbitration bubble between packets, including back-to-back packets from different channels.
- While out_valid=1 and out_ready=0, out_flit, out_last and out_sel hold stable. The source in_valid must also hold (standard valid/ready rule).

## Configuration
- PERIPHERAL_MPI_VC_MUX_REG_EN defined:
  - Output goes through a 2-entry skid register.
  - Latency is 1 cycle; throughput stays 1 flit/cycle.
  - All out_* are driven from flops.
  - The output-side ready used for in_ready is "skid not full", a registered signal, so there is no combinational out_ready→in_ready path.
  - Reset empties both entries.
- Not defined: pure combinational datapath as described under Timing.
- Arbitration and state-machine behaviour are identical in both builds.

## Structure
- Shared package peripheral_mpi_pkg holds:
  - state enum (IDLE, LOCKED)
  - helper constant for the pointer width, computed as $clog2(N) with a minimum of 1
- Sub-module peripheral_mpi_skid: 2-entry valid/ready skid register of width NOC_FLIT_WIDTH+1+N. Instantiated only under PERIPHERAL_MPI_VC_MUX_REG_EN.
- Round-robin search stays inline as a function.

## Test plan
1. N=2, macro off; ch0 sends 0xA0, 0xA1, 0xA2(last), out_ready=1 → the same three flits appear in the same cycles with out_sel=01, out_last only on 0xA2, ptr=1 afterwards.
2. Both channels present 2-flit packets in the first cycle after reset (ch0: 0x10, 0x11; ch1: 0x20, 0x21) → output 0x10, 0x11, 0x20, 0x21 with no interleave; in_ready[1]=0 for the first two cycles.
3. out_ready dropped for 3 cycles after the first flit of a locked 3-flit ch1 packet → out_flit holds the second flit, in_ready=00, no loss or duplication; resumes on out_ready=1.
4. Both channels stream continuous single-flit packets (last=1) → out_sel alternates 01, 10, 01, … every cycle, 1 flit/cycle.
5. rst pulsed for 1 cycle after flit 1 of a 3-flit ch0 packet, then only ch1 valid → out_valid=0 in the reset cycle, ch1 granted on the first cycle after reset, ch0 remnants not forwarded while ch0 in_valid=0.
6. Macro on, repeat scenario 1 with out_ready toggling 1,0,1,0 → flits emerge 1 cycle delayed, in order, none lost. in_ready never depends combinationally on out_ready (check by forcing out_ready and sampling in the same cycle).
